sanojn_ttrpg_dice: RTL and testbench

Tabletop dice roller for a Tiny Tapeout tile. Seven push-buttons select d4/d6/d8/d10/d12/d20/d100. While a button is held, a BCD counter cycles rapidly through 1..N. On release the count freezes, and that value is the roll. The result drives a two-digit multiplexed 7-segment display; button, segment and common-line polarities are configurable by pins.

---
 rtl/sanojn_ttrpg_dice_if.sv | 30 +++
 rtl/sanojn_ttrpg_dice.sv | 180 ++++++++++++++++++
 tb/tb_sanojn_ttrpg_dice.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sanojn_ttrpg_dice_if.sv
// ---------------------------------------------------------------------------
// sanojn_ttrpg_dice_if
//   Tile pin bundle for the dice roller.
//   ena     : tile enable (not used by the design)
//   ui_in   : push-buttons, bits 0..6 = d4, d6, d8, d10, d12, d20, d100
//   uio_in  : configuration, bit 5 button polarity, bit 6 segment polarity,
//             bit 7 common active level
//   uo_out  : segments a..g on bits 0..6, dp on bit 7
//   uio_out : bit 0 ones-digit common, bit 1 tens-digit common
//   uio_oe  : output enables for uio_out
// Modports: master drives the pins (bench / pad ring), slave is the design.
// ---------------------------------------------------------------------------
interface sanojn_ttrpg_dice_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/sanojn_ttrpg_dice.sv
// ---------------------------------------------------------------------------
// sanojn_ttrpg_dice
//   Tabletop dice roller. While a die button is held, a two-digit BCD value
//   steps 1..N once per clock; on release it freezes and is shown on a
//   two-digit multiplexed 7-segment display.
// Parameters:
//   MUX_BITS : each digit is shown for 2^MUX_BITS clocks
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active HIGH (name kept from the tile template)
//   io    : pin bundle (slave side), see sanojn_ttrpg_dice_if
// ---------------------------------------------------------------------------
module sanojn_ttrpg_dice #(
    parameter int MUX_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sanojn_ttrpg_dice_if.slave   io
);
    localparam int CW = MUX_BITS + 1;

    // Configuration pins act combinationally.
    logic btn_pol;
    logic seg_pol;
    logic com_act;
    assign btn_pol = io.uio_in[5];
    assign seg_pol = io.uio_in[6];
    assign com_act = io.uio_in[7];

    logic unused_pins;
    assign unused_pins = &{1'b0, io.ena, io.ui_in[7], io.uio_in[4:0]};

    // -----------------------------------------------------------------------
    // Button conditioning
    // -----------------------------------------------------------------------
    logic [6:0] sync1;
    logic [6:0] sync2;
    logic [6:0] pressed;
    logic       any_pressed;

    // The idle pin level depends on the polarity pin, so reset loads the
    // "not pressed" level for the current polarity.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1 <= {7{~btn_pol}};
            sync2 <= {7{~btn_pol}};
        end else begin
            sync1 <= io.ui_in[6:0];
            sync2 <= sync1;
        end
    end

    assign pressed     = ~(sync2 ^ {7{btn_pol}});
    assign any_pressed = |pressed;

    // Lowest pressed index selects the die.
    logic [6:0] limit;
    logic       sel_d100;

    always_comb begin
        limit    = 7'd4;
        sel_d100 = 1'b0;
        casez (pressed)
            7'b??????1: limit = 7'd4;
            7'b?????10: limit = 7'd6;
            7'b????100: limit = 7'd8;
            7'b???1000: limit = 7'd10;
            7'b??10000: limit = 7'd12;
            7'b?100000: limit = 7'd20;
            7'b1000000: begin
                limit    = 7'd100;
                sel_d100 = 1'b1;
            end
            default:    limit = 7'd4;
        endcase
    end

    // -----------------------------------------------------------------------
    // Rolling
    // -----------------------------------------------------------------------
    logic [3:0] digit1;
    logic [3:0] digit10;
    logic       d100_flag;
    logic [6:0] value_bin;
    logic       wrap;
    logic [3:0] next_d1;
    logic [3:0] next_d10;

    assign value_bin = 7'(digit10) * 7'd10 + 7'(digit1);

    // Zero covers both the post-reset value and the stored d100 "100";
    // anything at or above N (after a die switch) also restarts at 1.
    assign wrap = (value_bin >= limit) || (value_bin == 7'd0);

    always_comb begin
        next_d1  = digit1;
        next_d10 = digit10;
        if (wrap) begin
            next_d1  = 4'd1;
            next_d10 = 4'd0;
        end else if (digit1 == 4'd9) begin
            next_d1  = 4'd0;
            // 99 -> 100 is stored as tens 0, ones 0.
            next_d10 = (digit10 == 4'd9) ? 4'd0 : digit10 + 4'd1;
        end else begin
            next_d1  = digit1 + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            digit1    <= 4'd0;
            digit10   <= 4'd0;
            d100_flag <= 1'b0;
        end else if (any_pressed) begin
            digit1    <= next_d1;
            digit10   <= next_d10;
            d100_flag <= sel_d100;
        end
    end

    // -----------------------------------------------------------------------
    // Display
    // -----------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [CW-1:0] mux_cnt;
    logic          slot;
    logic          tens_blank;
    logic [6:0]    lit_next;
    logic [6:0]    lit_q;
    logic          slot_q;

    assign slot = mux_cnt[MUX_BITS];

    // Leading zero suppression, except for d100's "00" meaning 100.
    assign tens_blank = (digit10 == 4'd0) && !(d100_flag && digit1 == 4'd0);

    always_comb begin
        lit_next = seg_decode(digit1);
        if (slot) begin
            lit_next = tens_blank ? 7'h00 : seg_decode(digit10);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            mux_cnt <= '0;
            lit_q   <= 7'h3F;
            slot_q  <= 1'b0;
        end else begin
            mux_cnt <= mux_cnt + CW'(1);
            lit_q   <= lit_next;
            slot_q  <= slot;
        end
    end

    // dp stays unlit: lit value 0 before polarity is applied.
    assign io.uo_out  = seg_pol ? {1'b0, lit_q} : ~{1'b0, lit_q};
    assign io.uio_out = {6'b0,
                         slot_q ? com_act : ~com_act,
                         slot_q ? ~com_act : com_act};
    assign io.uio_oe  = 8'b0000_0011;
endmodule

// File: tb/tb_sanojn_ttrpg_dice.sv
module tb_sanojn_ttrpg_dice;
    localparam int MUX_BITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sanojn_ttrpg_dice_if io ();

    sanojn_ttrpg_dice #(.MUX_BITS(MUX_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [2:0] cfg;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // Pin level for a set of pressed buttons under current polarity.
    function automatic logic [7:0] pins(input logic [6:0] mask);
        return cfg[0] ? {1'b0, mask} : {1'b0, ~mask};
    endfunction

    task automatic do_reset(input logic [2:0] c);
        @(negedge clk);
        cfg        = c;
        io.uio_in  = {c, 5'b0};
        io.ui_in   = pins(7'h00);
        rst_n      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b0;
    endtask

    // Hold buttons for exactly 'steps' stepping clocks, then let it settle.
    task automatic roll(input logic [6:0] mask, input int steps);
        @(negedge clk);
        io.ui_in = pins(mask);
        repeat (steps) @(posedge clk);
        @(negedge clk);
        io.ui_in = pins(7'h00);
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // Wait until a given digit's common is active and return the segments.
    task automatic sample_slot(input int s, output logic [7:0] seg, output logic [1:0] com);
        int n;
        n = 0;
        while (io.uio_out[s] !== cfg[2] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("slot_timeout", 8'h01, 8'h00);
        seg = io.uo_out;
        com = io.uio_out[1:0];
    endtask

    logic [7:0] seg;
    logic [1:0] com;

    initial begin
        io.ena    = 1'b0;
        io.ui_in  = 8'h00;
        io.uio_in = 8'hE0;
        cfg       = 3'b111;

        // Reset display
        do_reset(3'b111);
        check("rst_digit1", {4'h0, dut.digit1}, 8'h00);
        check("rst_digit10", {4'h0, dut.digit10}, 8'h00);
        check("rst_uio_oe", io.uio_oe, 8'h03);
        check("rst_ones_seg", io.uo_out, 8'h3F);
        check("rst_ones_com", {6'b0, io.uio_out[1:0]}, 8'h01);
        sample_slot(1, seg, com);
        check("rst_tens_seg", seg, 8'h00);
        check("rst_tens_com", {6'b0, com}, 8'h02);

        // d20 roll of 25 steps -> 5, held indefinitely
        do_reset(3'b111);
        roll(7'b0100000, 25);
        check("d20_digit10", {4'h0, dut.digit10}, 8'h00);
        check("d20_digit1", {4'h0, dut.digit1}, 8'h05);
        repeat (10000) @(posedge clk);
        @(negedge clk);
        check("d20_hold", {dut.digit10, dut.digit1}, 8'h05);
        sample_slot(1, seg, com);
        check("d20_tens_seg", seg, 8'h00);
        sample_slot(0, seg, com);
        check("d20_ones_seg", seg, 8'h6D);

        // d6 wrap: latency to first step and the step sequence
        do_reset(3'b111);
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd1,
                  8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd1, 8'd2};
        @(negedge clk);
        io.ui_in = pins(7'b0000010);
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 14) io.ui_in = pins(7'h00);
            if (e < 3) check("d6_latency", {4'h0, dut.digit1}, 8'h00);
            else check("d6_seq", {4'h0, dut.digit1}, exp_q.pop_front());
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("d6_final", {dut.digit10, dut.digit1}, 8'h02);

        // d100 "00" means 100
        do_reset(3'b111);
        roll(7'b1000000, 100);
        check("d100_value", {dut.digit10, dut.digit1}, 8'h00);
        sample_slot(1, seg, com);
        check("d100_tens_seg", seg, 8'h3F);
        sample_slot(0, seg, com);
        check("d100_ones_seg", seg, 8'h3F);
        roll(7'b1000000, 1);
        check("d100_next", {dut.digit10, dut.digit1}, 8'h01);
        sample_slot(1, seg, com);
        check("d100_next_tens", seg, 8'h00);

        // Inverted polarities, d10 roll of 10 steps
        do_reset(3'b000);
        check("inv_idle_pins", io.ui_in, 8'h7F);
        roll(7'b0001000, 10);
        check("inv_value", {dut.digit10, dut.digit1}, 8'h10);
        sample_slot(1, seg, com);
        check("inv_tens_seg", seg, 8'hF9);
        check("inv_tens_com", {6'b0, com}, 8'h01);
        sample_slot(0, seg, com);
        check("inv_ones_seg", seg, 8'hC0);

        // Priority and die switch
        do_reset(3'b111);
        roll(7'b0100001, 9);
        check("prio_d4", {dut.digit10, dut.digit1}, 8'h01);
        roll(7'b0000001, 3);
        check("prio_to4", {dut.digit10, dut.digit1}, 8'h04);
        roll(7'b0100000, 17);
        check("switch_d20", {dut.digit10, dut.digit1}, 8'h01);

        // Reset mid-roll zeroes the result
        @(negedge clk);
        io.ui_in = pins(7'b0100000);
        repeat (7) @(posedge clk);
        do_reset(3'b111);
        check("rst_midroll", {dut.digit10, dut.digit1}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
